// File: rtl/pgm_prot_bus_bridge.sv
// pgm_prot_bus_bridge: 68k bus bridge to the IGS027A HLE protection block; PGM_PROT_TIMEOUT_EN enables the watchdog
module pgm_prot_bus_bridge #(
  parameter logic [23:0] BASE_ADDR = 24'h500000,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_as_n,
  input  logic        cpu_uds_n,
  input  logic        cpu_lds_n,
  input  logic        cpu_rw,
  input  logic [23:1] cpu_addr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_dtack_n,
  output logic [3:0]  prot_addr,
  output logic [15:0] prot_din,
  output logic        prot_we,
  output logic        prot_re,
  input  logic [15:0] prot_dout,
  input  logic        prot_dtack_n,
  output logic        timeout_err
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, ACK = 2'd3;
  logic [1:0] state;
  logic [1:0] as_sync;
  logic as_s, hit, rd, timeout;
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255 || BASE_ADDR[4:0] != 5'd0) begin : g_bad_param
    $error("pgm_prot_bus_bridge: illegal BASE_ADDR or TIMEOUT_CYC");
  end
  assign as_s = as_sync[1];
  assign hit = !as_s && cpu_addr[23:5] == BASE_ADDR[23:5] && (!cpu_uds_n || !cpu_lds_n);
`ifdef PGM_PROT_TIMEOUT_EN
  logic [7:0] cnt;
  assign timeout = cnt == 8'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= state == REQ ? 8'd0 : state == WAIT ? cnt + 8'd1 : cnt;
      if (state == WAIT && !as_s && prot_dtack_n && timeout) timeout_err <= 1'b1;
    end
`else
  assign timeout = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      as_sync <= 2'b11;
      state <= IDLE;
      rd <= 1'b0;
      cpu_dtack_n <= 1'b1;
      cpu_dout <= 16'hFFFF;
      prot_we <= 1'b0;
      prot_re <= 1'b0;
      prot_addr <= 4'd0;
      prot_din <= 16'd0;
    end else begin
      as_sync <= {as_sync[0], cpu_as_n};
      case (state)
        IDLE: if (hit) begin
          prot_addr <= cpu_addr[4:1];
          prot_din <= cpu_din;
          prot_we <= ~cpu_rw;
          prot_re <= cpu_rw;
          rd <= cpu_rw;
          state <= REQ;
        end
        REQ: begin
          prot_we <= 1'b0;
          prot_re <= 1'b0;
          state <= WAIT;
        end
        // an abort beats an acknowledge or watchdog expiry in the same cycle
        WAIT: if (as_s) state <= IDLE;
          else if (!prot_dtack_n || timeout) begin
            cpu_dtack_n <= 1'b0;
            if (rd) cpu_dout <= prot_dtack_n ? 16'hFFFF : prot_dout;
            state <= ACK;
          end
        default: if (as_s) begin
          cpu_dtack_n <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: doc/pgm_prot_bus_bridge.md
Name: pgm_prot_bus_bridge

Overview:
- 68000-side bus bridge that sits directly upstream of the IGS027A HLE protection register block.
- Synchronises the asynchronous 68k bus strobes and decodes the protection address window.
- Issues single-cycle write/read strobes with a 4-bit word index to the HLE block, captures its single-cycle dtack_n pulse and read data, then holds the 68k DTACK until the CPU ends the bus cycle.
- Optional watchdog forces termination of a cycle the HLE block never acknowledges.

Parameters:
- BASE_ADDR, 24'h500000, byte base address of the protection window; must be 32-byte aligned.
- TIMEOUT_CYC, 255, clk cycles spent in WAIT before a forced acknowledge; range 1..255, held in an 8-bit counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- cpu_as_n  in  1  68k address strobe, asynchronous to clk
- cpu_uds_n  in  1  68k upper data strobe
- cpu_lds_n  in  1  68k lower data strobe
- cpu_rw  in  1  68k read/write; 1 = read
- cpu_addr  in  23  68k address A[23:1]
- cpu_din  in  16  68k write data
- cpu_dout  out  16  read data returned to the 68k
- cpu_dtack_n  out  1  DTACK to the 68k, active-low
- prot_addr  out  4  word index to HLE, equal to A[4:1]
- prot_din  out  16  write data to HLE
- prot_we  out  1  single-cycle write strobe to HLE
- prot_re  out  1  single-cycle read strobe to HLE
- prot_dout  in  16  HLE read data; valid in the cycle prot_dtack_n is low
- prot_dtack_n  in  1  HLE acknowledge; a one-cycle low pulse
- timeout_err  out  1  sticky flag: at least one cycle terminated by the watchdog

Behaviour:
Reset values:
- cpu_dtack_n=1, cpu_dout=16'hFFFF, prot_we=0, prot_re=0, prot_addr=0, prot_din=0, timeout_err=0, state=IDLE, synchronisers=1.

Synchronisation:
- cpu_as_n passes through a 2-FF synchroniser; the result is as_s.
- cpu_addr, cpu_rw, cpu_din and the data strobes are sampled directly; they are stable while AS is low.

Hit condition:
- as_s=0, cpu_addr[23:5]==BASE_ADDR[23:5], and (uds_n=0 or lds_n=0).

FSM states: IDLE, REQ, WAIT, ACK.
- IDLE:
  - On hit: latch prot_addr<=A[4:1] and prot_din<=cpu_din; set prot_we<=~rw and prot_re<=rw; go to REQ.
  - No hit: no action. The bridge never drives DTACK for addresses outside the window.
- REQ (exactly one cycle):
  - The strobe is high for this cycle only; clear both strobes; reset the timeout counter; go to WAIT.
- WAIT:
  - prot_dtack_n=0: set cpu_dtack_n<=0. On a read, cpu_dout<=prot_dout; on a write, cpu_dout is unchanged. Go to ACK.
  - as_s=1 before the acknowledge (aborted cycle): go to IDLE without asserting DTACK. A late prot_dtack_n pulse arriving in IDLE is ignored.
  - If both occur in the same cycle, the abort wins.
  - Watchdog: see Optional Feature.
- ACK:
  - Hold cpu_dtack_n=0 while as_s=0.
  - When as_s=1: cpu_dtack_n<=1 and go to IDLE. A new cycle is accepted no earlier than the next clk.

Timing and data rules:
- Latency: clk edges are counted with edge 0 as the first edge that samples cpu_as_n low. For an HLE block that acknowledges in the cycle after the strobe:
  - strobe is high after edge 2;
  - cpu_dtack_n goes low after edge 4.
- Byte accesses are forwarded as full 16-bit accesses; cpu_din is passed unchanged and both bytes of prot_dout are returned.
- At most one outstanding HLE transaction. prot_we and prot_re are never high together and never high for more than one cycle.
- reset_n asserted mid-cycle returns all outputs to their reset values immediately, including releasing DTACK.

Optional Feature:
- Macro: PGM_PROT_TIMEOUT_EN.
- Defined:
  - An 8-bit counter increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC without prot_dtack_n: cpu_dtack_n<=0, cpu_dout<=16'hFFFF (reads only), timeout_err<=1 (sticky until reset), go to ACK.
- Not defined:
  - No counter; WAIT holds until an acknowledge or abort.
  - timeout_err is tied to 0.

Test Plan:
- Write 16'h0011 to byte address 0x500000 (HLE acks 1 cycle after strobe) -> one prot_we pulse with prot_addr=0, prot_din=16'h0011; cpu_dtack_n low after edge 4; released 1 cycle after as_s rises.
- Read 0x500002 with HLE returning 16'h55AA -> one prot_re pulse with prot_addr=1; cpu_dout=16'h55AA while cpu_dtack_n=0.
- Access 0x500040 and 0x4FFFFE -> no strobes; cpu_dtack_n stays 1.
- LDS-only write of 16'h00AB to 0x500006 -> prot_addr=3, prot_din=16'h00AB, single prot_we pulse.
- AS deasserted during WAIT, then a late HLE ack -> no DTACK, state IDLE; the next valid read completes normally.
- With PGM_PROT_TIMEOUT_EN and TIMEOUT_CYC=8, HLE never acks a read -> DTACK after 8 WAIT cycles, cpu_dout=16'hFFFF, timeout_err=1 until reset_n=0.
